// File: rtl/inst_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, fetches words from instruction memory over a req/ready
// handshake, and honours the decode pause and the decode branch redirect
// with MIPS single delay-slot semantics.
// Optional build macro: IFETCH_PERF_EN adds fetch/stall performance counters.
module inst_fetch #(
    localparam int unsigned XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pause,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic            valid_o
`ifdef IFETCH_PERF_EN
    ,
    output logic [XLEN-1:0] fetch_cnt_o,
    output logic [XLEN-1:0] stall_cnt_o
`endif
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_r, pc_d;
    logic [XLEN-1:0] buf_inst, buf_inst_d;
    logic [XLEN-1:0] buf_pc, buf_pc_d;
    logic            pend_v, pend_v_d;
    logic [XLEN-1:0] pend_tgt, pend_tgt_d;
    logic [XLEN-1:0] inst_d;
    logic [XLEN-1:0] pc_o_d;
    logic            valid_d;

    logic            br_acc_c;
    logic [XLEN-1:0] next_pc_c;

    // A redirect only counts when the branch is actually leaving decode.
    assign br_acc_c  = br_valid && valid_o && !pause;
    assign next_pc_c = pend_v   ? pend_tgt  :
                       br_acc_c ? br_target : pc_r + XLEN'(4);

    // Request is suppressed combinationally while reset is held.
    assign imem_req  = rst && (state_q == FETCH);
    assign imem_addr = pc_r;

    // Next-state and next-register computation for the fetch FSM.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_r;
        buf_inst_d = buf_inst;
        buf_pc_d   = buf_pc;
        pend_v_d   = pend_v;
        pend_tgt_d = pend_tgt;
        inst_d     = inst_o;
        pc_o_d     = pc_o;
        valid_d    = valid_o;

        case (state_q)
            FETCH: begin
                if (imem_ready) begin
                    pend_v_d = 1'b0;
                    pc_d     = next_pc_c;
                    if (!pause) begin
                        inst_d  = imem_rdata;
                        pc_o_d  = pc_r;
                        valid_d = 1'b1;
                    end else begin
                        // Decode is stalled: park the word until it frees up.
                        buf_inst_d = imem_rdata;
                        buf_pc_d   = pc_r;
                        state_d    = HOLD;
                    end
                end else if (!pause) begin
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                    // The fetch still in flight is the delay slot; remember the target.
                    if (br_acc_c) begin
                        pend_v_d   = 1'b1;
                        pend_tgt_d = br_target;
                    end
                end
            end
            HOLD: begin
                if (!pause) begin
                    inst_d  = buf_inst;
                    pc_o_d  = buf_pc;
                    valid_d = 1'b1;
                    state_d = FETCH;
                    // Buffered word is the delay slot; nothing is in flight.
                    if (br_acc_c) begin
                        pc_d = br_target;
                    end
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State, PC, skid buffer, pending redirect and IF/ID registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= FETCH;
            pc_r     <= RESET_PC;
            buf_inst <= '0;
            buf_pc   <= '0;
            pend_v   <= 1'b0;
            pend_tgt <= '0;
            inst_o   <= NOP_INST;
            pc_o     <= RESET_PC;
            valid_o  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_r     <= pc_d;
            buf_inst <= buf_inst_d;
            buf_pc   <= buf_pc_d;
            pend_v   <= pend_v_d;
            pend_tgt <= pend_tgt_d;
            inst_o   <= inst_d;
            pc_o     <= pc_o_d;
            valid_o  <= valid_d;
        end
    end

`ifdef IFETCH_PERF_EN
    logic fetch_done_c;
    logic stall_c;

    assign fetch_done_c = (state_q == FETCH) && imem_ready;
    assign stall_c      = pause || ((state_q == FETCH) && !imem_ready);

    // Completed-fetch and stall-cycle counters, wrapping mod 2^32.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (fetch_done_c) begin
                fetch_cnt_o <= fetch_cnt_o + XLEN'(1);
            end
            if (stall_c) begin
                stall_cnt_o <= stall_cnt_o + XLEN'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized
// run checked against a program-order model of the delivered stream.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst;
    logic        pause;
    logic        br_valid;
    logic [31:0] br_target;
    logic        imem_ready;

    logic        imem_req, imem_req_w;
    logic [31:0] imem_addr, imem_addr_w;
    logic [31:0] imem_rdata, imem_rdata_w;
    logic [31:0] inst_o, inst_o_w;
    logic [31:0] pc_o, pc_o_w;
    logic        valid_o, valid_o_w;
`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt, fetch_cnt_w, stall_cnt_w;
`endif

    int checks = 0;
    int errors = 0;

    // Instruction memory contents: a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0001;
    endfunction

    assign imem_rdata   = mem_word(imem_addr);
    assign imem_rdata_w = mem_word(imem_addr_w);

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .pause(pause), .br_valid(br_valid), .br_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata), .inst_o(inst_o), .pc_o(pc_o), .valid_o(valid_o)
`ifdef IFETCH_PERF_EN
        , .fetch_cnt_o(fetch_cnt), .stall_cnt_o(stall_cnt)
`endif
    );

    inst_fetch #(.RESET_PC(WRAP_PC), .NOP_INST(NOP)) dut_w (
        .clk(clk), .rst(rst), .pause(pause), .br_valid(br_valid), .br_target(br_target),
        .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_ready(imem_ready),
        .imem_rdata(imem_rdata_w), .inst_o(inst_o_w), .pc_o(pc_o_w), .valid_o(valid_o_w)
`ifdef IFETCH_PERF_EN
        , .fetch_cnt_o(fetch_cnt_w), .stall_cnt_o(stall_cnt_w)
`endif
    );

    // Hold reset two cycles, release at a falling edge ("cycle 0").
    task automatic restart();
        rst = 1'b0; pause = 1'b0; br_valid = 1'b0; br_target = '0; imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; pause = 1'b0; br_valid = 1'b0; br_target = '0; imem_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({imem_req, valid_o, inst_o, pc_o, imem_addr} !== {1'b0, 1'b0, NOP, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset got %h want %h", {imem_req, valid_o, inst_o, pc_o, imem_addr},
                     {1'b0, 1'b0, NOP, 32'h0, 32'h0});
        end
        checks++;
        if ({imem_req_w, valid_o_w, pc_o_w, imem_addr_w} !== {1'b0, 1'b0, WRAP_PC, WRAP_PC}) begin
            errors++;
            $display("FAIL reset_w got %h want %h", {imem_req_w, valid_o_w, pc_o_w, imem_addr_w},
                     {1'b0, 1'b0, WRAP_PC, WRAP_PC});
        end
    endtask

    task automatic test_sequential();
        logic [31:0] p;
        restart();
        checks++;
        if ({imem_req, valid_o, imem_addr} !== {1'b1, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL seq_start got %h want %h", {imem_req, valid_o, imem_addr}, {1'b1, 1'b0, 32'h0});
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            p = 32'(4 * (k - 1));
            checks++;
            if ({valid_o, pc_o, inst_o, imem_addr} !== {1'b1, p, mem_word(p), p + 32'd4}) begin
                errors++;
                $display("FAIL seq k=%0d got %h want %h", k, {valid_o, pc_o, inst_o, imem_addr},
                         {1'b1, p, mem_word(p), p + 32'd4});
            end
        end
    endtask

    task automatic test_pause();
        restart();
        repeat (4) @(negedge clk);
        pause = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({imem_req, valid_o, pc_o, inst_o} !== {1'b0, 1'b1, 32'h0C, mem_word(32'h0C)}) begin
                errors++;
                $display("FAIL pause_hold i=%0d got %h want %h", i, {imem_req, valid_o, pc_o, inst_o},
                         {1'b0, 1'b1, 32'h0C, mem_word(32'h0C)});
            end
        end
        pause = 1'b0;
        @(negedge clk);
        checks++;
        if ({valid_o, pc_o, inst_o, imem_req, imem_addr} !== {1'b1, 32'h10, mem_word(32'h10), 1'b1, 32'h14}) begin
            errors++;
            $display("FAIL pause_release got %h want %h", {valid_o, pc_o, inst_o, imem_req, imem_addr},
                     {1'b1, 32'h10, mem_word(32'h10), 1'b1, 32'h14});
        end
    endtask

    task automatic test_branch();
        restart();
        repeat (9) @(negedge clk);
        br_valid = 1'b1; br_target = 32'h100;
        @(negedge clk);
        br_valid = 1'b0;
        checks++;
        if ({valid_o, pc_o, inst_o, imem_addr} !== {1'b1, 32'h24, mem_word(32'h24), 32'h100}) begin
            errors++;
            $display("FAIL branch_slot got %h want %h", {valid_o, pc_o, inst_o, imem_addr},
                     {1'b1, 32'h24, mem_word(32'h24), 32'h100});
        end
        @(negedge clk);
        checks++;
        if ({pc_o, inst_o, imem_addr} !== {32'h100, mem_word(32'h100), 32'h104}) begin
            errors++;
            $display("FAIL branch_target got %h want %h", {pc_o, inst_o, imem_addr},
                     {32'h100, mem_word(32'h100), 32'h104});
        end
    endtask

    task automatic test_branch_stall();
        restart();
        repeat (9) @(negedge clk);
        br_valid = 1'b1; br_target = 32'h100; imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            br_valid = 1'b0;
            checks++;
            if ({valid_o, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h24}) begin
                errors++;
                $display("FAIL bstall_bubble i=%0d got %h want %h", i, {valid_o, imem_req, imem_addr},
                         {1'b0, 1'b1, 32'h24});
            end
        end
        imem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid_o, pc_o, inst_o, imem_addr} !== {1'b1, 32'h24, mem_word(32'h24), 32'h100}) begin
            errors++;
            $display("FAIL bstall_pend got %h want %h", {valid_o, pc_o, inst_o, imem_addr},
                     {1'b1, 32'h24, mem_word(32'h24), 32'h100});
        end
    endtask

    task automatic test_branch_hold();
        restart();
        repeat (9) @(negedge clk);
        // Branch is paused in decode, so this redirect must be ignored.
        pause = 1'b1; br_valid = 1'b1; br_target = 32'h300;
        @(negedge clk);
        checks++;
        if ({imem_req, valid_o, pc_o} !== {1'b0, 1'b1, 32'h20}) begin
            errors++;
            $display("FAIL bhold_wait got %h want %h", {imem_req, valid_o, pc_o}, {1'b0, 1'b1, 32'h20});
        end
        pause = 1'b0; br_valid = 1'b1; br_target = 32'h200;
        @(negedge clk);
        br_valid = 1'b0;
        checks++;
        if ({valid_o, pc_o, inst_o, imem_req, imem_addr} !== {1'b1, 32'h24, mem_word(32'h24), 1'b1, 32'h200}) begin
            errors++;
            $display("FAIL bhold_release got %h want %h", {valid_o, pc_o, inst_o, imem_req, imem_addr},
                     {1'b1, 32'h24, mem_word(32'h24), 1'b1, 32'h200});
        end
    endtask

    task automatic test_wrap_and_reset();
        restart();
        checks++;
        if ({imem_req_w, imem_addr_w} !== {1'b1, WRAP_PC}) begin
            errors++;
            $display("FAIL wrap_start got %h want %h", {imem_req_w, imem_addr_w}, {1'b1, WRAP_PC});
        end
        @(negedge clk);
        checks++;
        if ({valid_o_w, pc_o_w, inst_o_w, imem_addr_w} !== {1'b1, WRAP_PC, mem_word(WRAP_PC), 32'h0}) begin
            errors++;
            $display("FAIL wrap_next got %h want %h", {valid_o_w, pc_o_w, inst_o_w, imem_addr_w},
                     {1'b1, WRAP_PC, mem_word(WRAP_PC), 32'h0});
        end
        imem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({imem_req_w, imem_req} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_req got %b want 00", {imem_req_w, imem_req});
        end
        @(negedge clk);
        checks++;
        if ({valid_o_w, imem_req_w, pc_o_w, inst_o_w, imem_addr_w} !== {1'b0, 1'b0, WRAP_PC, NOP, WRAP_PC}) begin
            errors++;
            $display("FAIL midreset_state got %h want %h", {valid_o_w, imem_req_w, pc_o_w, inst_o_w, imem_addr_w},
                     {1'b0, 1'b0, WRAP_PC, NOP, WRAP_PC});
        end
        rst = 1'b1; imem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({valid_o_w, pc_o_w, imem_addr_w} !== {1'b1, WRAP_PC, 32'h0}) begin
            errors++;
            $display("FAIL midreset_restart got %h want %h", {valid_o_w, pc_o_w, imem_addr_w},
                     {1'b1, WRAP_PC, 32'h0});
        end
    endtask

    // Random stall/pause/branch traffic; the model tracks only program order:
    // after a taken branch comes its sequential delay slot, then the target.
    task automatic test_random();
        logic [31:0] exp_pc, tgt, prev_addr;
        logic        after_slot, prev_wait;
        int          consumed, idle;
        exp_pc = 32'h0; tgt = '0; after_slot = 1'b0; prev_wait = 1'b0; prev_addr = '0;
        consumed = 0; idle = 0;
        restart();
        for (int n = 0; n < 3000; n++) begin
            if (prev_wait) begin
                checks++;
                if ({imem_req, imem_addr} !== {1'b1, prev_addr}) begin
                    errors++;
                    $display("FAIL rand_addr_stable n=%0d got %h want %h", n, {imem_req, imem_addr}, {1'b1, prev_addr});
                end
            end
            pause      = ($urandom_range(0, 3) == 0);
            imem_ready = ($urandom_range(0, 2) != 0);
            br_valid   = !after_slot && ($urandom_range(0, 3) == 0);
            br_target  = $urandom() & 32'hFFFF_FFFC;
            #1;
            if (valid_o && !pause) begin
                checks++;
                if ({pc_o, inst_o} !== {exp_pc, mem_word(exp_pc)}) begin
                    errors++;
                    $display("FAIL rand_stream n=%0d got %h want %h", n, {pc_o, inst_o}, {exp_pc, mem_word(exp_pc)});
                end
                if (after_slot) begin
                    exp_pc = tgt;
                    after_slot = 1'b0;
                end else if (br_valid) begin
                    tgt = br_target;
                    after_slot = 1'b1;
                    exp_pc = exp_pc + 32'd4;
                end else begin
                    exp_pc = exp_pc + 32'd4;
                end
                consumed++;
                idle = 0;
            end else begin
                idle++;
                if (idle > 64) begin
                    checks++;
                    errors++;
                    $display("FAIL rand_progress n=%0d idle %0d cycles, limit 64", n, idle);
                    break;
                end
            end
            prev_wait = imem_req && !imem_ready;
            prev_addr = imem_addr;
            @(negedge clk);
        end
        pause = 1'b0; br_valid = 1'b0; imem_ready = 1'b1;
        checks++;
        if (consumed < 500) begin
            errors++;
            $display("FAIL rand_throughput got %0d want >= 500", consumed);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_pause();
        test_branch();
        test_branch_stall();
        test_branch_hold();
        test_wrap_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
